// File: rtl/id_imm_stage_pkg.sv
// Shared definitions for the IF/ID stage: base opcodes, raw immediate
// field widths and the skid-buffer occupancy states.
package id_imm_stage_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  // Raw field widths shared with the sign-extension unit
  localparam int unsigned IMM1_LEN = 12;
  localparam int unsigned IMM2_LEN = 20;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                immsel;
    logic [IMM1_LEN-1:0] imm1;
    logic [IMM2_LEN-1:0] imm2;
    logic                shl1;
    logic                illegal;
  } dec_t;

endpackage

// File: rtl/id_imm_decode.sv
// Combinational instruction decoder: register indices, instruction format
// and the raw (unextended) immediate fields.
module id_imm_decode
  import id_imm_stage_pkg::*;
(
  input  logic [31:0]          inst_i,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic                 immsel_o,
  output logic [IMM1_LEN-1:0]  imm1_o,
  output logic [IMM2_LEN-1:0]  imm2_o,
  output logic                 shl1_o,
  output logic                 illegal_o
);

  logic [6:0] opc;

  assign opc   = inst_i[6:0];
  assign rs1_o = inst_i[19:15];
  assign rs2_o = inst_i[24:20];
  assign rd_o  = inst_i[11:7];

  always_comb begin
    immsel_o  = 1'b1;
    imm1_o    = '0;
    imm2_o    = '0;
    shl1_o    = 1'b0;
    illegal_o = 1'b0;
    if (inst_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (opc)
        OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM: begin
          imm1_o = inst_i[31:20];
        end
        OPC_STORE: begin
          imm1_o = {inst_i[31:25], inst_i[11:7]};
        end
        OPC_BRANCH: begin
          imm1_o = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8]};
          shl1_o = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: begin
          immsel_o = 1'b0;
          imm2_o   = inst_i[31:12];
        end
        OPC_JAL: begin
          immsel_o = 1'b0;
          imm2_o   = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21]};
          shl1_o   = 1'b1;
        end
        OPC_OP, OPC_OP32: begin
          imm1_o = '0;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_imm_stage.sv
// IF/ID pipeline stage: 2-entry skid buffer of decoded fetch bundles.
// Decode happens at the input so every output is driven from a flop.
module id_imm_stage
  import id_imm_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [ILEN-1:0]     inst_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [ILEN-1:0]     inst_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [4:0]          rd_o,
  output logic                immsel_o,
  output logic [IMM1_LEN-1:0] imm1_o,
  output logic [IMM2_LEN-1:0] imm2_o,
  output logic                imm_shl1_o,
  output logic                illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    dec_t            dec;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   in_fire, out_fire;

  id_imm_decode u_decode (
    .inst_i    (inst_i[31:0]),
    .rs1_o     (in_entry.dec.rs1),
    .rs2_o     (in_entry.dec.rs2),
    .rd_o      (in_entry.dec.rd),
    .immsel_o  (in_entry.dec.immsel),
    .imm1_o    (in_entry.dec.imm1),
    .imm2_o    (in_entry.dec.imm2),
    .shl1_o    (in_entry.dec.shl1),
    .illegal_o (in_entry.dec.illegal)
  );

  assign in_entry.pc   = pc_i;
  assign in_entry.inst = inst_i;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            head_d  = in_entry;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_d = in_entry;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can occur
          if (out_fire) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign pc_o        = head_q.pc;
  assign inst_o      = head_q.inst;
  assign rs1_o       = head_q.dec.rs1;
  assign rs2_o       = head_q.dec.rs2;
  assign rd_o        = head_q.dec.rd;
  assign immsel_o    = head_q.dec.immsel;
  assign imm1_o      = head_q.dec.imm1;
  assign imm2_o      = head_q.dec.imm2;
  assign imm_shl1_o  = head_q.dec.shl1;
  assign illegal_o   = head_q.dec.illegal;

endmodule

// File: tb/tb_id_imm_stage.sv
// Bench for id_imm_stage: directed scenarios plus random traffic checked
// against a queue-based reference with arithmetic immediate reconstruction.
module tb_id_imm_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] pc_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] pc_o;
  logic [31:0] inst_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        immsel_o;
  logic [11:0] imm1_o;
  logic [19:0] imm2_o;
  logic        imm_shl1_o;
  logic        illegal_o;

  id_imm_stage #(.XLEN(64), .ILEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .rs1_o       (rs1_o),
    .rs2_o       (rs2_o),
    .rd_o        (rd_o),
    .immsel_o    (immsel_o),
    .imm1_o      (imm1_o),
    .imm2_o      (imm2_o),
    .imm_shl1_o  (imm_shl1_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        immsel;
    logic [11:0] imm1;
    logic [19:0] imm2;
    logic        shl1;
    logic        illegal;
  } exp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];
  logic m_rdy;
  logic last_acc;
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic int unsigned fld(input int unsigned x, input int unsigned lo, input int unsigned w);
    return (x >> lo) & ((32'd1 << w) - 32'd1);
  endfunction

  // Reference: rebuild the architectural byte offset, then express the
  // raw field as that offset (halved for B/J).
  function automatic exp_t ref_dec(input logic [31:0] ins);
    exp_t e;
    int unsigned x, op, off;
    x = ins;
    op = fld(x, 0, 7);
    e = '0;
    e.rs1 = 5'(fld(x, 15, 5));
    e.rs2 = 5'(fld(x, 20, 5));
    e.rd  = 5'(fld(x, 7, 5));
    e.immsel = 1'b1;
    if (fld(x, 0, 2) != 3) begin
      e.illegal = 1'b1;
    end else begin
      case (op)
        3, 19, 27, 103, 115: e.imm1 = 12'(fld(x, 20, 12));
        35: e.imm1 = 12'(fld(x, 25, 7) * 32 + fld(x, 7, 5));
        99: begin
          off = fld(x, 31, 1) * 4096 + fld(x, 7, 1) * 2048 + fld(x, 25, 6) * 32 + fld(x, 8, 4) * 2;
          e.imm1 = 12'(off / 2);
          e.shl1 = 1'b1;
        end
        55, 23: begin
          e.immsel = 1'b0;
          e.imm2 = 20'(fld(x, 12, 20));
        end
        111: begin
          off = fld(x, 31, 1) * (1 << 20) + fld(x, 12, 8) * 4096 + fld(x, 20, 1) * 2048 + fld(x, 21, 10) * 2;
          e.immsel = 1'b0;
          e.imm2 = 20'(off / 2);
          e.shl1 = 1'b1;
        end
        51, 59: e.imm1 = 12'd0;
        default: e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("in_ready", 64'(in_ready_o), 64'(m_rdy));
    chk("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      e = ref_dec(mq[0].inst);
      chk("pc", pc_o, mq[0].pc);
      chk("inst", 64'(inst_o), 64'(mq[0].inst));
      chk("rs1", 64'(rs1_o), 64'(e.rs1));
      chk("rs2", 64'(rs2_o), 64'(e.rs2));
      chk("rd", 64'(rd_o), 64'(e.rd));
      chk("immsel", 64'(immsel_o), 64'(e.immsel));
      chk("imm1", 64'(imm1_o), 64'(e.imm1));
      chk("imm2", 64'(imm2_o), 64'(e.imm2));
      chk("shl1", 64'(imm_shl1_o), 64'(e.shl1));
      chk("illegal", 64'(illegal_o), 64'(e.illegal));
    end
  endtask

  // One clock: drive, check at the falling edge, then advance the model.
  task automatic cycle(input logic v, input logic [63:0] p, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    logic inf, outf;
    in_valid_i = v; pc_i = p; inst_i = ins; out_ready_i = ordy; flush_i = fl;
    @(negedge clk);
    check_outputs();
    inf  = v & m_rdy;
    outf = (mq.size() != 0) & ordy;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back('{pc: p, inst: ins});
    end
    m_rdy = (mq.size() != 2);
    last_acc = inf & !fl;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12];
    logic [31:0] r;
    int unsigned sel;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
    r = $urandom;
    sel = $urandom_range(0, 13);
    if (sel < 12) r[6:0] = ops[sel];
    return r;
  endfunction

  task automatic drop_all_inputs();
    in_valid_i = 1'b0; pc_i = '0; inst_i = '0; out_ready_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    logic acc;
    drop_all_inputs();
    rst = 1'b0;
    m_rdy = 1'b0;
    last_acc = 1'b0;

    // Reset values
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_pc", pc_o, 64'd0);
    chk("rst_imm1", 64'(imm1_o), 64'd0);
    chk("rst_imm2", 64'(imm2_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_in_ready_low", 64'(in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_high", 64'(in_ready_o), 64'd1);
    m_rdy = 1'b1;

    // addi x1,x2,-1
    cycle(1'b1, 64'h80000000, 32'hFFF10093, 1'b1, 1'b0);
    chk("addi_valid", 64'(out_valid_o), 64'd1);
    chk("addi_rd", 64'(rd_o), 64'd1);
    chk("addi_rs1", 64'(rs1_o), 64'd2);
    chk("addi_immsel", 64'(immsel_o), 64'd1);
    chk("addi_imm1", 64'(imm1_o), 64'hFFF);
    chk("addi_shl1", 64'(imm_shl1_o), 64'd0);
    chk("addi_illegal", 64'(illegal_o), 64'd0);

    // lui x5,0x12345
    cycle(1'b1, 64'h80000004, 32'h123452B7, 1'b1, 1'b0);
    chk("lui_immsel", 64'(immsel_o), 64'd0);
    chk("lui_imm2", 64'(imm2_o), 64'h12345);
    chk("lui_rd", 64'(rd_o), 64'd5);
    chk("lui_imm1", 64'(imm1_o), 64'd0);

    // jal x1,+8
    cycle(1'b1, 64'h80000008, 32'h008000EF, 1'b1, 1'b0);
    chk("jal_immsel", 64'(immsel_o), 64'd0);
    chk("jal_imm2", 64'(imm2_o), 64'h00004);
    chk("jal_shl1", 64'(imm_shl1_o), 64'd1);
    chk("jal_rd", 64'(rd_o), 64'd1);

    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: three back-to-back bundles, downstream stalled
    cycle(1'b1, 64'hA00, 32'h00A00093, 1'b0, 1'b0);
    cycle(1'b1, 64'hB00, 32'h00B00113, 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
    chk("bp_head_is_first", pc_o, 64'hA00);
    cycle(1'b1, 64'hC00, 32'h00C00193, 1'b0, 1'b0);
    chk("bp_third_rejected", 64'(last_acc), 64'd0);
    chk("bp_head_stable", pc_o, 64'hA00);
    cycle(1'b1, 64'hC00, 32'h00C00193, 1'b1, 1'b0);
    chk("bp_second_to_head", pc_o, 64'hB00);
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) begin
      cycle(1'b1, 64'hC00, 32'h00C00193, 1'b1, 1'b0);
      acc = last_acc;
    end
    chk("bp_third_accepted", 64'(acc), 64'd1);
    chk("bp_third_at_head", pc_o, 64'hC00);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full, with a same-cycle input offered
    cycle(1'b1, 64'hD00, 32'h00000013, 1'b0, 1'b0);
    cycle(1'b1, 64'hD04, 32'h00100013, 1'b0, 1'b0);
    cycle(1'b1, 64'hD08, 32'h00200013, 1'b0, 1'b1);
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_in_ready", 64'(in_ready_o), 64'd1);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_stays_empty", 64'(out_valid_o), 64'd0);

    // Illegal all-zero word, then reset mid-stream
    cycle(1'b1, 64'hE00, 32'h00000000, 1'b0, 1'b0);
    chk("ill_valid", 64'(out_valid_o), 64'd1);
    chk("ill_flag", 64'(illegal_o), 64'd1);
    chk("ill_imm1", 64'(imm1_o), 64'd0);
    chk("ill_imm2", 64'(imm2_o), 64'd0);
    cycle(1'b1, 64'hE04, 32'h00500293, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_in_ready", 64'(in_ready_o), 64'd0);
    chk("arst_pc", pc_o, 64'd0);
    mq.delete();
    m_rdy = 1'b0;
    drop_all_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_rel_low", 64'(in_ready_o), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_rel_high", 64'(in_ready_o), 64'd1);
    m_rdy = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), {32'h0, $urandom}, rand_inst(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
